// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    localparam int DEPTH_DEF = 256;
    localparam int AW_DEF    = 8;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // A header word count is usable only if it names at least one word and fits the RAM.
    function automatic logic hdr_ok(input logic [31:0] n, input int depth);
        return (n != 32'd0) && (n <= 32'(depth));
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus instruction-RAM write port of the loader.
// Latency: n/a (wiring only).
// Backpressure: in_ready qualifies in_valid; the RAM port has no backpressure.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int AW = AW_DEF
) ();
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;

    // Byte source / RAM observer side.
    modport master (
        output in_valid, in_data,
        input  in_ready, we, wa, wd
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, we, wa, wd
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// Latency: word_valid/word_dat are combinational with the 4th accepted byte.
// Backpressure: none internally; the caller qualifies byte_vld with its ready.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_valid,
    output logic [31:0] word_dat
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;

    // Earlier bytes sit in the low part of the word, so shift new bytes in from the top.
    assign word_valid = byte_vld & ~clr & (cnt_q == 2'd3);
    assign word_dat   = {byte_dat, sr_q};

    // Next byte count / shift contents; a clear drops any byte arriving alongside it.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clr) begin
            cnt_d = 2'd0;
            sr_d  = 24'd0;
        end else if (byte_vld) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {byte_dat, sr_q[23:8]};
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction RAM, holding the core until done.
// Latency: RAM write one cycle after the 4th byte of each word; done one cycle after the last write.
// Backpressure: in_ready high in HDR/LOAD, low once finished or on a bad header.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] nlast_q, nlast_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [31:0]   wd_q, wd_d;
    logic          done_q, done_d;
    logic          hold_q, hold_d;

    logic          in_ready;
    logic          xfer;
    logic          word_vld;
    logic [31:0]   word_dat;

    assign in_ready = (state_q == ST_HDR) || (state_q == ST_LOAD);
    assign xfer     = bus.in_valid & in_ready;

    byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (start),
        .byte_vld   (xfer),
        .byte_dat   (bus.in_data),
        .word_valid (word_vld),
        .word_dat   (word_dat)
    );

    // FSM next state, word index and write-port staging; start overrides everything.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nlast_d = nlast_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        done_d  = (state_q == ST_DONE);
        hold_d  = (state_q != ST_DONE);
        if (start) begin
            state_d = ST_HDR;
            idx_d   = '0;
            done_d  = 1'b0;
            hold_d  = 1'b1;
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (word_vld) begin
                        if (hdr_ok(word_dat, DEPTH)) begin
                            state_d = ST_LOAD;
                            idx_d   = '0;
                            // Keep N-1 so the last index fits AW bits even when N == DEPTH.
                            nlast_d = AW'(word_dat - 32'd1);
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_vld) begin
                        we_d = 1'b1;
                        wa_d = idx_q;
                        wd_d = word_dat;
                        // Final word: stop the index here so it never wraps.
                        if (idx_q == nlast_q) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, index and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HDR;
            idx_q   <= '0;
            nlast_q <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= 32'd0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nlast_q <= nlast_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.we       = we_q;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = (state_q == ST_ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, bad headers, gaps, start abort, reset abort, full depth.
// Latency: checks the write exactly one cycle after each 4th byte.
// Backpressure: random in_valid gaps between bytes.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic cpu_hold;
    logic done;
    logic error;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;

    imem_loader_if #(.AW(8)) bus ();

    imem_loader #(.DEPTH(256), .AW(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Count write strobes sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.we) wr_count++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; presents one byte after 'gap' idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] n, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], $urandom_range(0, maxgap));
        chk("hdr_no_we", {31'd0, bus.we}, 32'd0);
    endtask

    // Sends a payload word and checks the single-cycle write that must follow its 4th byte.
    task automatic send_word(input logic [31:0] w, input logic [31:0] exp_wa, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
        chk("wr_we", {31'd0, bus.we}, 32'd1);
        chk("wr_wa", {24'd0, bus.wa}, exp_wa);
        chk("wr_wd", bus.wd, w);
        @(posedge clk);
        #1;
        chk("wr_one_cycle", {31'd0, bus.we}, 32'd0);
    endtask

    task automatic pulse_start(input logic with_byte, input logic [7:0] b);
        start        = 1'b1;
        bus.in_valid = with_byte;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, bus.we}, 32'd0);
        chk("rst_wa", {24'd0, bus.wa}, 32'd0);
        chk("rst_wd", bus.wd, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // Two-word load; first byte presented for the first edge after reset release
        reset_n = 1'b1;
        send_hdr(32'd2, 0);
        chk("a_err", {31'd0, error}, 32'd0);
        send_word(32'h00100513, 32'd0, 0);
        chk("a_hold_mid", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h00200593, 32'd1, 0);
        chk("a_done", {31'd0, done}, 32'd1);
        chk("a_hold", {31'd0, cpu_hold}, 32'd0);
        chk("a_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("a_wa_hold", {24'd0, bus.wa}, 32'd1);
        chk("a_wd_hold", bus.wd, 32'h00200593);
        chk("a_wrcnt", wr_count, 32'd2);

        // Invalid headers: N=0 and N=257
        pulse_start(1'b0, 8'h00);
        chk("b_done_clr", {31'd0, done}, 32'd0);
        chk("b_hold_set", {31'd0, cpu_hold}, 32'd1);
        chk("b_ready", {31'd0, bus.in_ready}, 32'd1);
        send_hdr(32'd0, 0);
        chk("b0_error", {31'd0, error}, 32'd1);
        chk("b0_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("b0_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h55, 0);
        send_byte(8'h66, 2);
        chk("b0_wrcnt", wr_count, 32'd2);
        pulse_start(1'b0, 8'h00);
        chk("b_err_clr", {31'd0, error}, 32'd0);
        send_hdr(32'd257, 0);
        chk("b257_error", {31'd0, error}, 32'd1);
        chk("b257_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("b257_wrcnt", wr_count, 32'd2);

        // Same two-word stream with random in_valid gaps
        pulse_start(1'b0, 8'h00);
        send_hdr(32'd2, 5);
        send_word(32'h00100513, 32'd0, 5);
        send_word(32'h00200593, 32'd1, 5);
        chk("c_done", {31'd0, done}, 32'd1);
        chk("c_wrcnt", wr_count, 32'd4);

        // Abort by start after 6 payload bytes, with a byte offered alongside start
        pulse_start(1'b0, 8'h00);
        send_hdr(32'd2, 0);
        send_word(32'hAABBCCDD, 32'd0, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pulse_start(1'b1, 8'h33);
        chk("d_we", {31'd0, bus.we}, 32'd0);
        chk("d_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("d_hold", {31'd0, cpu_hold}, 32'd1);
        send_hdr(32'd1, 0);
        chk("d_hdr_err", {31'd0, error}, 32'd0);
        send_word(32'h12345678, 32'd0, 0);
        chk("d_done", {31'd0, done}, 32'd1);
        chk("d_wrcnt", wr_count, 32'd6);

        // Reset pulse while a write strobe is high
        pulse_start(1'b0, 8'h00);
        send_hdr(32'd3, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        chk("e_we_pre", {31'd0, bus.we}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("e_we", {31'd0, bus.we}, 32'd0);
        chk("e_wa", {24'd0, bus.wa}, 32'd0);
        chk("e_wd", bus.wd, 32'd0);
        chk("e_done", {31'd0, done}, 32'd0);
        chk("e_error", {31'd0, error}, 32'd0);
        chk("e_hold", {31'd0, cpu_hold}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("e_wrcnt", wr_count, 32'd6);
        reset_n = 1'b1;
        send_hdr(32'd2, 0);
        send_word(32'h00100513, 32'd0, 0);
        send_word(32'h00200593, 32'd1, 0);
        chk("e_done_after", {31'd0, done}, 32'd1);
        chk("e_wrcnt_after", wr_count, 32'd8);

        // Full depth: N=256, payload word k = k
        pulse_start(1'b0, 8'h00);
        send_hdr(32'd256, 0);
        chk("f_err", {31'd0, error}, 32'd0);
        for (int k = 0; k < 256; k++) send_word(32'(k), 32'(k), 0);
        chk("f_done", {31'd0, done}, 32'd1);
        chk("f_hold", {31'd0, cpu_hold}, 32'd0);
        chk("f_wa_last", {24'd0, bus.wa}, 32'd255);
        chk("f_wd_last", bus.wd, 32'h000000FF);
        chk("f_wrcnt", wr_count, 32'd264);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        repeat (4) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("f_no_wrap", wr_count, 32'd264);
        chk("f_done_stay", {31'd0, done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory depth in 32-bit words.
REQ-002 Parameter AW, default 8: word-address width; SHALL satisfy 2**AW == DEPTH.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse; restarts a load session.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  loader can accept a byte.
REQ-009 we  output  1  instruction-RAM write strobe, one cycle per word.
REQ-010 wa  output  AW  instruction-RAM word address.
REQ-011 wd  output  32  instruction-RAM write data.
REQ-012 cpu_hold  output  1  holds the core in reset while high.
REQ-013 done  output  1  load completed successfully (level).
REQ-014 error  output  1  invalid header (level).

Function
REQ-015 A byte transfers only in a cycle where in_valid and in_ready are both 1.
REQ-016 Bytes assemble little-endian: the 1st byte of a group goes to bits [7:0] and the 4th byte to bits [31:24].
REQ-017 The states SHALL be HDR, LOAD, DONE and ERR; in_ready SHALL be 1 in HDR and LOAD, and 0 in DONE and ERR.
REQ-018 HDR: the first 4-byte group is word count N; on the 4th byte, 1<=N<=DEPTH -> LOAD; otherwise -> ERR.
REQ-019 LOAD: after each 4th byte, the block SHALL, on the next cycle, assert we=1 for exactly one cycle, with wa = word index and wd = the assembled word.
REQ-020 Word index SHALL start at 0 and increment after each write; it SHALL never wrap and never exceed N-1.
REQ-021 The cycle carrying write number N (index N-1) SHALL also move the state to DONE; done=1 and cpu_hold=0 take effect the following cycle.
REQ-022 In HDR, LOAD and ERR, cpu_hold=1; done=0 outside DONE; error=1 only in ERR.
REQ-023 When we=0, wa and wd SHALL hold their last values.
REQ-024 start in any state SHALL go to HDR and clear the byte counter, word index, done and error; cpu_hold returns to 1.
REQ-025 If start coincides with a byte transfer, start wins and the byte is discarded.
REQ-026 Gaps in in_valid between bytes SHALL NOT change the assembled result or the write timing relative to the 4th byte.

Reset
REQ-027 While reset_n=0: state=HDR, byte counter=0, word index=0, we=0, wa=0, wd=0, done=0, error=0, cpu_hold=1.
REQ-028 Reset asserted mid-load SHALL abort immediately; no further write occurs, and already-written RAM words are not cleared.
REQ-029 The first byte can be accepted in the first clock edge after reset_n rises.

Structure
REQ-030 The shared package imem_loader_pkg SHALL hold the state enumeration and the defaults for DEPTH and AW.
REQ-031 Byte-to-word assembly SHALL live in one sub-module, byte_packer, containing the 2-bit counter and shift register and producing a word_valid pulse.
REQ-032 The top level SHALL contain the FSM, word-index counter and write-port registers; the target size is 120-400 lines of RTL.

Verification
REQ-033 Load of two words: bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 -> we at wa=0 with wd=0x00100513, then at wa=1 with wd=0x00200593; then done=1, cpu_hold=0, in_ready=0.
REQ-034 Invalid header counts: bytes 00 00 00 00 -> error=1 with no writes; bytes 01 01 00 00 (N=257) -> error=1 with no writes.
REQ-035 Full depth: N=256 with payload word k = k -> 256 writes, last at wa=255 with wd=0x000000FF, no wrap, then done=1.
REQ-036 Backpressure: the REQ-033 stream with random 0-5 cycle in_valid gaps -> identical writes, each exactly 1 cycle after its 4th byte.
REQ-037 Abort by start: start after 6 payload bytes, with a simultaneous byte transfer -> byte dropped; a new header is required; the next session writes from wa=0.
REQ-038 Abort by reset: reset_n pulsed low mid-LOAD -> we=0 immediately and all outputs at reset values; a subsequent clean load succeeds.
